// File: rtl/riscv_decode_stage_pkg.sv
// rtl/riscv_decode_stage_pkg.sv - RV32I decode constants, bundle type and buffer states
package riscv_decode_stage_pkg;

    localparam int ALU_OP_WIDTH = 4;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 4'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 4'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LT   = 4'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GE   = 4'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 4'd14;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 4'd15;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_LSU = 2'd1;
    localparam logic [1:0] WB_MDU = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    localparam logic [1:0] OPA_RS1  = 2'd0;
    localparam logic [1:0] OPA_PC   = 2'd1;
    localparam logic [1:0] OPA_ZERO = 2'd2;

    localparam logic [2:0] OPB_RS2   = 3'd0;
    localparam logic [2:0] OPB_IMM_I = 3'd1;
    localparam logic [2:0] OPB_IMM_U = 3'd2;
    localparam logic [2:0] OPB_IMM_S = 3'd3;
    localparam logic [2:0] OPB_FOUR  = 3'd4;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [31:0]             pc;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [4:0]              rd;
        logic [1:0]              op_a_sel;
        logic [2:0]              op_b_sel;
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic                    mem_req;
        logic                    mem_we;
        logic [2:0]              mem_size;
        logic                    gpr_we;
        logic [1:0]              wb_src_sel;
        logic                    mdu_req;
        logic [2:0]              mdu_op;
        logic                    csr_req;
        logic [2:0]              csr_op;
        logic                    branch;
        logic                    jal;
        logic                    jalr;
        logic                    illegal;
    } dec_bundle_t;

endpackage

// File: rtl/riscv_decode_comb.sv
// rtl/riscv_decode_comb.sv - combinational RV32I(+M, Zicsr) instruction to decode bundle
module riscv_decode_comb
    import riscv_decode_stage_pkg::*;
#(
    parameter bit EN_M_EXT = 1'b1,
    parameter bit EN_CSR   = 1'b1
) (
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output dec_bundle_t bundle_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       ill;
    dec_bundle_t b;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        b          = '0;
        ill        = 1'b0;
        b.pc       = pc_i;
        b.rs1      = instr_i[19:15];
        b.rs2      = instr_i[24:20];
        b.rd       = instr_i[11:7];
        b.alu_op   = ALU_ADD;
        b.mem_size = funct3;

        if (opcode[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD: begin
                    b.op_b_sel   = OPB_IMM_I;
                    b.mem_req    = 1'b1;
                    b.gpr_we     = 1'b1;
                    b.wb_src_sel = WB_LSU;
                    if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) ill = 1'b1;
                end
                OPC_STORE: begin
                    b.op_b_sel = OPB_IMM_S;
                    b.mem_req  = 1'b1;
                    b.mem_we   = 1'b1;
                    if (funct3 > 3'd2) ill = 1'b1;
                end
                OPC_OP_IMM: begin
                    b.op_b_sel = OPB_IMM_I;
                    b.gpr_we   = 1'b1;
                    case (funct3)
                        3'd0: b.alu_op = ALU_ADD;
                        3'd2: b.alu_op = ALU_SLT;
                        3'd3: b.alu_op = ALU_SLTU;
                        3'd4: b.alu_op = ALU_XOR;
                        3'd6: b.alu_op = ALU_OR;
                        3'd7: b.alu_op = ALU_AND;
                        3'd1: begin
                            b.alu_op = ALU_SLL;
                            if (funct7 != 7'd0) ill = 1'b1;
                        end
                        default: begin
                            if (funct7 == 7'd0)                b.alu_op = ALU_SRL;
                            else if (funct7 == 7'b0100000)     b.alu_op = ALU_SRA;
                            else                               ill = 1'b1;
                        end
                    endcase
                end
                OPC_OP: begin
                    b.gpr_we = 1'b1;
                    if (funct7 == 7'd0) begin
                        case (funct3)
                            3'd0:    b.alu_op = ALU_ADD;
                            3'd1:    b.alu_op = ALU_SLL;
                            3'd2:    b.alu_op = ALU_SLT;
                            3'd3:    b.alu_op = ALU_SLTU;
                            3'd4:    b.alu_op = ALU_XOR;
                            3'd5:    b.alu_op = ALU_SRL;
                            3'd6:    b.alu_op = ALU_OR;
                            default: b.alu_op = ALU_AND;
                        endcase
                    end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                        b.alu_op = ALU_SUB;
                    end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                        b.alu_op = ALU_SRA;
                    end else if (funct7 == 7'b0000001 && EN_M_EXT) begin
                        b.mdu_req    = 1'b1;
                        b.mdu_op     = funct3;
                        b.wb_src_sel = WB_MDU;
                    end else begin
                        ill = 1'b1;
                    end
                end
                OPC_LUI: begin
                    b.op_a_sel = OPA_ZERO;
                    b.op_b_sel = OPB_IMM_U;
                    b.gpr_we   = 1'b1;
                end
                OPC_AUIPC: begin
                    b.op_a_sel = OPA_PC;
                    b.op_b_sel = OPB_IMM_U;
                    b.gpr_we   = 1'b1;
                end
                OPC_BRANCH: begin
                    b.branch = 1'b1;
                    case (funct3)
                        3'd0:    b.alu_op = ALU_EQ;
                        3'd1:    b.alu_op = ALU_NE;
                        3'd4:    b.alu_op = ALU_LT;
                        3'd5:    b.alu_op = ALU_GE;
                        3'd6:    b.alu_op = ALU_LTU;
                        3'd7:    b.alu_op = ALU_GEU;
                        default: ill = 1'b1;
                    endcase
                end
                OPC_JAL, OPC_JALR: begin
                    b.op_a_sel = OPA_PC;
                    b.op_b_sel = OPB_FOUR;
                    b.gpr_we   = 1'b1;
                    b.jal      = (opcode == OPC_JAL);
                    b.jalr     = (opcode == OPC_JALR);
                    if (opcode == OPC_JALR && funct3 != 3'd0) ill = 1'b1;
                end
                OPC_MISC_MEM: ;
                OPC_SYSTEM: begin
                    // funct3==0 (ECALL/EBREAK) passes through as a NOP; funct3==4 is unallocated
                    if (funct3 != 3'd0) begin
                        if (EN_CSR && funct3 != 3'd4) begin
                            b.csr_req    = 1'b1;
                            b.csr_op     = funct3;
                            b.gpr_we     = 1'b1;
                            b.wb_src_sel = WB_CSR;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                end
                default: ill = 1'b1;
            endcase
        end

        b.illegal = ill;
        if (ill) begin
            b.gpr_we  = 1'b0;
            b.mem_req = 1'b0;
            b.mem_we  = 1'b0;
            b.branch  = 1'b0;
            b.jal     = 1'b0;
            b.jalr    = 1'b0;
            b.mdu_req = 1'b0;
            b.csr_req = 1'b0;
        end
    end

    assign bundle_o = b;

endmodule

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - registered decode stage with 2-entry skid buffer and illegal counter
module riscv_decode_stage
    import riscv_decode_stage_pkg::*;
#(
    parameter bit EN_M_EXT = 1'b1,
    parameter bit EN_CSR   = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [31:0]             instr_i,
    input  logic [31:0]             pc_i,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    output logic                    dec_valid_o,
    input  logic                    dec_ready_i,
    output logic [31:0]             pc_o,
    output logic [4:0]              rs1_o,
    output logic [4:0]              rs2_o,
    output logic [4:0]              rd_o,
    output logic [1:0]              ex_op_a_sel_o,
    output logic [2:0]              ex_op_b_sel_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [2:0]              mem_size_o,
    output logic                    gpr_we_a_o,
    output logic [1:0]              wb_src_sel_o,
    output logic                    mdu_req_o,
    output logic [2:0]              mdu_op_o,
    output logic                    csr_req_o,
    output logic [2:0]              csr_op_o,
    output logic                    branch_o,
    output logic                    jal_o,
    output logic                    jalr_o,
    output logic                    illegal_instr_o,
    output logic [CNT_W-1:0]        illegal_cnt_o
);

    buf_state_t  state_q, state_d;
    dec_bundle_t main_q, main_d;
    dec_bundle_t skid_q, skid_d;
    dec_bundle_t dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic accept, consume;

    riscv_decode_comb #(
        .EN_M_EXT (EN_M_EXT),
        .EN_CSR   (EN_CSR)
    ) u_decode_comb (
        .instr_i  (instr_i),
        .pc_i     (pc_i),
        .bundle_o (dec)
    );

    assign instr_ready_o = (state_q != BUF_TWO);
    assign dec_valid_o   = (state_q != BUF_EMPTY);
    assign accept        = instr_valid_i & instr_ready_o;
    assign consume       = dec_valid_o & dec_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d = BUF_ONE;
                        main_d  = dec;
                    end
                end
                BUF_ONE: begin
                    if (accept && !consume) begin
                        state_d = BUF_TWO;
                        skid_d  = dec;
                    end else if (accept && consume) begin
                        main_d  = dec;
                    end else if (consume) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (consume) begin
                        state_d = BUF_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
            if (accept && dec.illegal && cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pc_o            = main_q.pc;
    assign rs1_o           = main_q.rs1;
    assign rs2_o           = main_q.rs2;
    assign rd_o            = main_q.rd;
    assign ex_op_a_sel_o   = main_q.op_a_sel;
    assign ex_op_b_sel_o   = main_q.op_b_sel;
    assign alu_op_o        = main_q.alu_op;
    assign mem_req_o       = main_q.mem_req;
    assign mem_we_o        = main_q.mem_we;
    assign mem_size_o      = main_q.mem_size;
    assign gpr_we_a_o      = main_q.gpr_we;
    assign wb_src_sel_o    = main_q.wb_src_sel;
    assign mdu_req_o       = main_q.mdu_req;
    assign mdu_op_o        = main_q.mdu_op;
    assign csr_req_o       = main_q.csr_req;
    assign csr_op_o        = main_q.csr_op;
    assign branch_o        = main_q.branch;
    assign jal_o           = main_q.jal;
    assign jalr_o          = main_q.jalr;
    assign illegal_instr_o = main_q.illegal;
    assign illegal_cnt_o   = cnt_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb/tb_riscv_decode_stage.sv - directed self-checking bench for riscv_decode_stage
module tb_riscv_decode_stage;
    import riscv_decode_stage_pkg::*;

    logic clk = 1'b0;
    logic rst, flush, instr_valid, dec_ready;
    logic [31:0] instr, pc;
    int checks = 0;
    int failures = 0;

    logic instr_ready, dec_valid, mem_req, mem_we, gpr_we, mdu_req, csr_req, branch, jal, jalr, illegal;
    logic [31:0] pc_o;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] op_a, wb_src;
    logic [2:0] op_b, mem_size, mdu_op, csr_op;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [3:0] cnt;

    logic n_instr_ready, n_dec_valid, n_mem_req, n_mem_we, n_gpr_we, n_mdu_req, n_csr_req;
    logic n_branch, n_jal, n_jalr, n_illegal;
    logic [31:0] n_pc_o;
    logic [4:0] n_rs1, n_rs2, n_rd;
    logic [1:0] n_op_a, n_wb_src;
    logic [2:0] n_op_b, n_mem_size, n_mdu_op, n_csr_op;
    logic [ALU_OP_WIDTH-1:0] n_alu_op;
    logic [15:0] n_cnt;

    always #5 clk = ~clk;

    riscv_decode_stage #(.EN_M_EXT(1'b1), .EN_CSR(1'b1), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .dec_valid_o(dec_valid),
        .dec_ready_i(dec_ready), .pc_o(pc_o), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .ex_op_a_sel_o(op_a), .ex_op_b_sel_o(op_b), .alu_op_o(alu_op), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_size_o(mem_size), .gpr_we_a_o(gpr_we), .wb_src_sel_o(wb_src),
        .mdu_req_o(mdu_req), .mdu_op_o(mdu_op), .csr_req_o(csr_req), .csr_op_o(csr_op),
        .branch_o(branch), .jal_o(jal), .jalr_o(jalr), .illegal_instr_o(illegal),
        .illegal_cnt_o(cnt)
    );

    riscv_decode_stage #(.EN_M_EXT(1'b0), .EN_CSR(1'b0), .CNT_W(16)) dut_nom (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc),
        .instr_valid_i(instr_valid), .instr_ready_o(n_instr_ready), .dec_valid_o(n_dec_valid),
        .dec_ready_i(dec_ready), .pc_o(n_pc_o), .rs1_o(n_rs1), .rs2_o(n_rs2), .rd_o(n_rd),
        .ex_op_a_sel_o(n_op_a), .ex_op_b_sel_o(n_op_b), .alu_op_o(n_alu_op), .mem_req_o(n_mem_req),
        .mem_we_o(n_mem_we), .mem_size_o(n_mem_size), .gpr_we_a_o(n_gpr_we), .wb_src_sel_o(n_wb_src),
        .mdu_req_o(n_mdu_req), .mdu_op_o(n_mdu_op), .csr_req_o(n_csr_req), .csr_op_o(n_csr_op),
        .branch_o(n_branch), .jal_o(n_jal), .jalr_o(n_jalr), .illegal_instr_o(n_illegal),
        .illegal_cnt_o(n_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p);
        instr = i; pc = p; instr_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b1; instr = '0; pc = '0;
        step(); step();
        rst = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", dec_valid); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", instr_ready); end
        checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", cnt); end
        checks++; if ({pc_o, gpr_we, alu_op, op_b} !== '0) begin failures++; $display("FAIL reset_bundle got=%0h exp=0", {pc_o, gpr_we, alu_op, op_b}); end
    endtask

    task automatic test_addi();
        drive(32'h00500093, 32'h100);
        step();
        instr_valid = 1'b0;
        checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", dec_valid); end
        checks++; if (alu_op !== ALU_ADD) begin failures++; $display("FAIL addi_alu got=%0h exp=%0h", alu_op, ALU_ADD); end
        checks++; if (op_b !== 3'd1) begin failures++; $display("FAIL addi_opb got=%0h exp=1", op_b); end
        checks++; if (rd !== 5'd1 || rs1 !== 5'd0) begin failures++; $display("FAIL addi_regs got=%0h/%0h exp=1/0", rd, rs1); end
        checks++; if (gpr_we !== 1'b1 || illegal !== 1'b0) begin failures++; $display("FAIL addi_we_ill got=%0h/%0h exp=1/0", gpr_we, illegal); end
        checks++; if (pc_o !== 32'h100) begin failures++; $display("FAIL addi_pc got=%0h exp=100", pc_o); end
        step();
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%0h exp=0", dec_valid); end
    endtask

    task automatic test_mul();
        drive(32'h022081B3, 32'h104);
        step();
        instr_valid = 1'b0;
        checks++; if (mdu_req !== 1'b1 || mdu_op !== 3'd0) begin failures++; $display("FAIL mul_mdu got=%0h/%0h exp=1/0", mdu_req, mdu_op); end
        checks++; if (wb_src !== 2'd2 || rd !== 5'd3 || illegal !== 1'b0) begin failures++; $display("FAIL mul_wb got=%0h rd=%0h ill=%0h exp=2/3/0", wb_src, rd, illegal); end
        checks++; if (n_illegal !== 1'b1 || n_cnt !== 16'd1) begin failures++; $display("FAIL mul_nom_ill got=%0h cnt=%0h exp=1/1", n_illegal, n_cnt); end
        checks++; if (n_mdu_req !== 1'b0 || n_gpr_we !== 1'b0) begin failures++; $display("FAIL mul_nom_side got=%0h/%0h exp=0/0", n_mdu_req, n_gpr_we); end
        checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL mul_cnt got=%0h exp=0", cnt); end
        step();
    endtask

    task automatic test_illegal_load();
        drive(32'h0000B003, 32'h108);
        step();
        instr_valid = 1'b0;
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ldbad_ill got=%0h exp=1", illegal); end
        checks++; if (mem_req !== 1'b0 || gpr_we !== 1'b0) begin failures++; $display("FAIL ldbad_side got=%0h/%0h exp=0/0", mem_req, gpr_we); end
        checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL ldbad_cnt got=%0h exp=1", cnt); end
        step();
    endtask

    task automatic test_misc();
        drive(32'h123452B7, 32'h200);   // lui x5,0x12345
        step();
        checks++; if (op_a !== 2'd2 || op_b !== 3'd2 || gpr_we !== 1'b1 || rd !== 5'd5) begin failures++; $display("FAIL lui got=%0h/%0h/%0h/%0h exp=2/2/1/5", op_a, op_b, gpr_we, rd); end
        drive(32'h0020A423, 32'h204);   // sw x2,8(x1)
        step();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_size !== LDST_W || op_b !== 3'd3 || gpr_we !== 1'b0) begin failures++; $display("FAIL sw got=%0h/%0h/%0h/%0h/%0h exp=1/1/2/3/0", mem_req, mem_we, mem_size, op_b, gpr_we); end
        drive(32'h000000EF, 32'h208);   // jal x1,0
        step();
        checks++; if (op_a !== 2'd1 || op_b !== 3'd4 || jal !== 1'b1 || jalr !== 1'b0 || gpr_we !== 1'b1 || alu_op !== ALU_ADD) begin failures++; $display("FAIL jal got=%0h/%0h/%0h/%0h exp=1/4/1/1", op_a, op_b, jal, gpr_we); end
        drive(32'h4010D093, 32'h20C);   // srai x1,x1,1
        step();
        checks++; if (alu_op !== ALU_SRA || illegal !== 1'b0) begin failures++; $display("FAIL srai got=%0h ill=%0h exp=%0h/0", alu_op, illegal, ALU_SRA); end
        drive(32'h40109093, 32'h210);   // slli with funct7=0100000
        step();
        checks++; if (illegal !== 1'b1 || gpr_we !== 1'b0 || cnt !== 4'd2) begin failures++; $display("FAIL slli_bad got=%0h/%0h cnt=%0h exp=1/0/2", illegal, gpr_we, cnt); end
        drive(32'h300110F3, 32'h214);   // csrrw x1,0x300,x2
        step();
        instr_valid = 1'b0;
        checks++; if (csr_req !== 1'b1 || csr_op !== 3'd1 || wb_src !== 2'd3 || gpr_we !== 1'b1) begin failures++; $display("FAIL csr got=%0h/%0h/%0h/%0h exp=1/1/3/1", csr_req, csr_op, wb_src, gpr_we); end
        checks++; if (n_illegal !== 1'b1 || n_csr_req !== 1'b0) begin failures++; $display("FAIL csr_nom got=%0h/%0h exp=1/0", n_illegal, n_csr_req); end
        step();
    endtask

    task automatic test_back_to_back();
        dec_ready = 1'b0;
        drive(32'h00100093, 32'h300);   // addi x1
        step();
        checks++; if (instr_ready !== 1'b1 || pc_o !== 32'h300) begin failures++; $display("FAIL b2b_c1 got=%0h pc=%0h exp=1/300", instr_ready, pc_o); end
        drive(32'h00100113, 32'h304);   // addi x2
        step();
        checks++; if (instr_ready !== 1'b0 || pc_o !== 32'h300) begin failures++; $display("FAIL b2b_c2 got=%0h pc=%0h exp=0/300", instr_ready, pc_o); end
        drive(32'h00100193, 32'h308);   // addi x3
        step();
        checks++; if (dec_valid !== 1'b1 || pc_o !== 32'h300 || rd !== 5'd1) begin failures++; $display("FAIL b2b_hold got=%0h pc=%0h rd=%0h exp=1/300/1", dec_valid, pc_o, rd); end
        dec_ready = 1'b1;
        step();
        checks++; if (pc_o !== 32'h304 || rd !== 5'd2 || instr_ready !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0h rd=%0h rdy=%0h exp=304/2/1", pc_o, rd, instr_ready); end
        step();
        instr_valid = 1'b0;
        checks++; if (pc_o !== 32'h308 || rd !== 5'd3 || dec_valid !== 1'b1) begin failures++; $display("FAIL b2b_third got=%0h rd=%0h v=%0h exp=308/3/1", pc_o, rd, dec_valid); end
        step();
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0h exp=0", dec_valid); end
    endtask

    task automatic test_flush();
        dec_ready = 1'b0;
        drive(32'h00100093, 32'h400);
        step();
        drive(32'h00100113, 32'h404);
        step();
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL flush_two got=%0h exp=0", instr_ready); end
        flush = 1'b1;
        drive(32'h00000000, 32'h499);
        step();
        flush = 1'b0; instr_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL flush_two_next got=%0h/%0h exp=0/1", dec_valid, instr_ready); end
        step();
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL flush_no_emit got=%0h exp=0", dec_valid); end
        drive(32'h00100093, 32'h408);
        step();
        flush = 1'b1;
        drive(32'h00000000, 32'h40C);
        step();
        flush = 1'b0; instr_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0 || cnt !== 4'd2) begin failures++; $display("FAIL flush_one got=%0h cnt=%0h exp=0/2", dec_valid, cnt); end
        dec_ready = 1'b1;
        step();
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL flush_one_next got=%0h exp=0", dec_valid); end
    endtask

    task automatic test_saturate_and_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dec_ready = 1'b1;
        drive(32'h00000000, 32'h500);
        for (int i = 0; i < 14; i++) step();
        checks++; if (cnt !== 4'd14) begin failures++; $display("FAIL sat_14 got=%0h exp=14", cnt); end
        for (int i = 0; i < 5; i++) step();
        checks++; if (cnt !== 4'd15 || illegal !== 1'b1) begin failures++; $display("FAIL sat_hold got=%0h ill=%0h exp=15/1", cnt, illegal); end
        rst = 1'b1;
        step();
        rst = 1'b0; instr_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0 || cnt !== 4'd0 || illegal !== 1'b0 || pc_o !== 32'h0 || instr_ready !== 1'b1) begin failures++; $display("FAIL midrst got=%0h cnt=%0h ill=%0h pc=%0h rdy=%0h exp=0/0/0/0/1", dec_valid, cnt, illegal, pc_o, instr_ready); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_mul();
        test_illegal_load();
        test_misc();
        test_back_to_back();
        test_flush();
        test_saturate_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
